// File: rtl/fp8_align.sv
// fp8_align: exponent compare and serial (1 bit/clk) mantissa alignment for the FP8 add/sub path.
// Define FP8_ALIGN_STICKY_EN to build the sticky accumulator; otherwise out_sticky is tied to 0.
module fp8_align #(
    parameter int unsigned EXP_W  = 3,
    parameter int unsigned FRAC_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   op_a,
    input  logic [EXP_W+FRAC_W:0]   op_b,
    input  logic                    mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign_a,
    output logic                    out_sign_b,
    output logic                    out_mode,
    output logic [EXP_W:0]          out_exp_diff,
    output logic [EXP_W-1:0]        out_exp_max,
    output logic [FRAC_W-1:0]       out_frac_a,
    output logic [FRAC_W-1:0]       out_frac_b,
    output logic [FRAC_W+1:0]       out_man_a,
    output logic [FRAC_W+1:0]       out_man_b,
    output logic                    out_sticky
);
    localparam int unsigned MAN_W  = FRAC_W + 2;
    localparam int unsigned DIFF_W = EXP_W + 1;
    localparam int unsigned CNT_W  = $clog2(MAN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;

    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [DIFF_W-1:0] diff, diff_mag;
    logic [CNT_W-1:0]  n_init;
    logic              b_smaller;

    logic              valid_next, sign_a_next, sign_b_next, mode_next;
    logic [DIFF_W-1:0] exp_diff_next;
    logic [EXP_W-1:0]  exp_max_next;
    logic [FRAC_W-1:0] frac_a_next, frac_b_next;
    logic [MAN_W-1:0]  man_a_next, man_b_next;

`ifdef FP8_ALIGN_STICKY_EN
    logic sticky, sticky_next;
    assign out_sticky = sticky;
`else
    assign out_sticky = 1'b0;
`endif

    // Shift amount is taken from the raw exponents and saturates at the mantissa width.
    assign exp_a     = op_a[FRAC_W +: EXP_W];
    assign exp_b     = op_b[FRAC_W +: EXP_W];
    assign diff      = {1'b0, exp_a} - {1'b0, exp_b};
    assign diff_mag  = diff[EXP_W] ? (~diff + DIFF_W'(1)) : diff;
    assign n_init    = (32'(diff_mag) > MAN_W) ? CNT_W'(MAN_W) : CNT_W'(diff_mag);
    assign b_smaller = ~out_exp_diff[EXP_W];
    assign in_ready  = (state == IDLE) && !rst;

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        valid_next    = out_valid;
        sign_a_next   = out_sign_a;
        sign_b_next   = out_sign_b;
        mode_next     = out_mode;
        exp_diff_next = out_exp_diff;
        exp_max_next  = out_exp_max;
        frac_a_next   = out_frac_a;
        frac_b_next   = out_frac_b;
        man_a_next    = out_man_a;
        man_b_next    = out_man_b;
`ifdef FP8_ALIGN_STICKY_EN
        sticky_next   = sticky;
`endif
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_a_next   = op_a[EXP_W+FRAC_W];
                    sign_b_next   = op_b[EXP_W+FRAC_W];
                    mode_next     = mode;
                    exp_diff_next = diff;
                    exp_max_next  = diff[EXP_W] ? exp_b : exp_a;
                    frac_a_next   = op_a[FRAC_W-1:0];
                    frac_b_next   = op_b[FRAC_W-1:0];
                    man_a_next    = {|exp_a, op_a[FRAC_W-1:0], 1'b0};
                    man_b_next    = {|exp_b, op_b[FRAC_W-1:0], 1'b0};
                    cnt_next      = n_init;
                    state_next    = (n_init != '0) ? SHIFT : DONE;
`ifdef FP8_ALIGN_STICKY_EN
                    sticky_next   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (b_smaller) begin
                    man_b_next = {1'b0, out_man_b[MAN_W-1:1]};
                end else begin
                    man_a_next = {1'b0, out_man_a[MAN_W-1:1]};
                end
`ifdef FP8_ALIGN_STICKY_EN
                sticky_next = sticky | (b_smaller ? out_man_b[0] : out_man_a[0]);
`endif
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE and drops on the accepting edge.
                if (out_valid && out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end else begin
                    valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_sign_a   <= 1'b0;
            out_sign_b   <= 1'b0;
            out_mode     <= 1'b0;
            out_exp_diff <= '0;
            out_exp_max  <= '0;
            out_frac_a   <= '0;
            out_frac_b   <= '0;
            out_man_a    <= '0;
            out_man_b    <= '0;
`ifdef FP8_ALIGN_STICKY_EN
            sticky       <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            out_valid    <= valid_next;
            out_sign_a   <= sign_a_next;
            out_sign_b   <= sign_b_next;
            out_mode     <= mode_next;
            out_exp_diff <= exp_diff_next;
            out_exp_max  <= exp_max_next;
            out_frac_a   <= frac_a_next;
            out_frac_b   <= frac_b_next;
            out_man_a    <= man_a_next;
            out_man_b    <= man_b_next;
`ifdef FP8_ALIGN_STICKY_EN
            sticky       <= sticky_next;
`endif
        end
    end
endmodule

// File: tb/tb_fp8_align.sv
// tb_fp8_align: directed vector table plus hand-written backpressure, reset and back-to-back sequences.
module tb_fp8_align;
`ifdef FP8_ALIGN_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, mode, out_valid, out_ready;
    logic [7:0] op_a, op_b;
    logic       out_sign_a, out_sign_b, out_mode, out_sticky;
    logic [3:0] out_exp_diff, out_frac_a, out_frac_b;
    logic [2:0] out_exp_max;
    logic [5:0] out_man_a, out_man_b;

    fp8_align #(.EXP_W(3), .FRAC_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign_a(out_sign_a), .out_sign_b(out_sign_b), .out_mode(out_mode),
        .out_exp_diff(out_exp_diff), .out_exp_max(out_exp_max),
        .out_frac_a(out_frac_a), .out_frac_b(out_frac_b),
        .out_man_a(out_man_a), .out_man_b(out_man_b), .out_sticky(out_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        int         lat;
        logic [3:0] diff;
        logic [2:0] emax;
        logic [5:0] ma;
        logic [5:0] mb;
        logic [3:0] fa;
        logic [3:0] fb;
        logic       sa;
        logic       sb;
        logic       stk;
    } vec_t;

    vec_t vecs [7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic check_fields(input vec_t v, input string tag);
        check({tag, " exp_diff"}, 32'(out_exp_diff), 32'(v.diff));
        check({tag, " exp_max"},  32'(out_exp_max),  32'(v.emax));
        check({tag, " man_a"},    32'(out_man_a),    32'(v.ma));
        check({tag, " man_b"},    32'(out_man_b),    32'(v.mb));
        check({tag, " frac_a"},   32'(out_frac_a),   32'(v.fa));
        check({tag, " frac_b"},   32'(out_frac_b),   32'(v.fb));
        check({tag, " sign_a"},   32'(out_sign_a),   32'(v.sa));
        check({tag, " sign_b"},   32'(out_sign_b),   32'(v.sb));
        check({tag, " mode"},     32'(out_mode),     32'(v.m));
        check({tag, " sticky"},   32'(out_sticky),   32'(v.stk & STICKY_ON));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 0);
        check({tag, " out_word"},
              32'({out_sign_a, out_sign_b, out_mode, out_exp_diff, out_exp_max}), 0);
        check({tag, " fracs"}, 32'({out_frac_a, out_frac_b}), 0);
        check({tag, " mans"},  32'({out_man_a, out_man_b}), 0);
        check({tag, " sticky"}, 32'(out_sticky), 0);
    endtask

    // Call at a negedge with the stage idle; returns at the negedge after the capture edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m);
        check("send in_ready", 32'(in_ready), 1);
        op_a = a; op_b = b; mode = m; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // lat = number of edges after the capture edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int   lat, got, t1, t2, seen;
    logic acc;

    initial begin
        vecs[0] = '{8'h35, 8'h13, 1'b0, 3, 4'b0010, 3'd3, 6'h2A, 6'h09, 4'h5, 4'h3, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h45, 8'hC3, 1'b1, 1, 4'b0000, 3'd4, 6'h2A, 6'h26, 4'h5, 4'h3, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h70, 1'b0, 7, 4'b1010, 3'd7, 6'h00, 6'h20, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h0F, 8'h21, 1'b0, 3, 4'b1110, 3'd2, 6'h07, 6'h22, 4'hF, 4'h1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h83, 8'h85, 1'b1, 1, 4'b0000, 3'd0, 6'h06, 6'h0A, 4'h3, 4'h5, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h74, 8'h68, 1'b0, 2, 4'b0001, 3'd7, 6'h28, 6'h18, 4'h4, 4'h8, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h70, 8'h00, 1'b1, 7, 4'b0111, 3'd7, 6'h20, 6'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};

        // Reset with in_valid asserted: nothing may be captured.
        rst = 1'b1; in_valid = 1'b1; op_a = 8'h35; op_b = 8'h13; mode = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 0);
        check_zero("reset");
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post-reset in_ready", 32'(in_ready), 1);
        @(negedge clk);
        check_zero("no capture under rst");

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].m);
            wait_valid(lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check_fields(vecs[i], $sformatf("v%0d", i));
            @(negedge clk);
            check($sformatf("v%0d release out_valid", i), 32'(out_valid), 0);
            check($sformatf("v%0d release in_ready", i), 32'(in_ready), 1);
        end

        // Backpressure: hold results for 5 cycles, a stray in_valid pulse must be ignored.
        out_ready = 1'b0;
        send(8'h35, 8'h13, 1'b0);
        wait_valid(lat);
        check("bp latency", 32'(lat), 3);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 1);
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 0);
            check($sformatf("bp%0d mans", k), 32'({out_man_a, out_man_b}), 32'({6'h2A, 6'h09}));
            check($sformatf("bp%0d sticky", k), 32'(out_sticky), 32'(STICKY_ON));
            if (k == 1) begin
                op_a = 8'h70; op_b = 8'h00; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 32'(out_valid), 0);
        check("bp release in_ready", 32'(in_ready), 1);
        check("bp held frac_a", 32'(out_frac_a), 5);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("bp no phantom result", 32'(seen), 0);

        // Reset during SHIFT of the saturating case: the transaction disappears.
        send(8'h10, 8'h70, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid-shift reset in_ready", 32'(in_ready), 1);
        check_zero("mid-shift reset");
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("mid-shift reset no result", 32'(seen), 0);

        // Back-to-back: in_valid held high, second operands presented right after the first capture.
        send(8'h35, 8'h13, 1'b0);
        op_a = 8'h45; op_b = 8'hC3; mode = 1'b1; in_valid = 1'b1;
        got = 0; t1 = -1; t2 = -1;
        for (int k = 1; k <= 14; k++) begin
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            if (out_valid) begin
                if (got == 0) begin
                    t1 = k;
                    check_fields(vecs[0], "b2b first");
                end else if (got == 1) begin
                    t2 = k;
                    check_fields(vecs[1], "b2b second");
                end
                got++;
            end
        end
        in_valid = 1'b0;
        check("b2b result count", 32'(got), 2);
        check("b2b first time", 32'(t1), 3);
        // second: accept edge 4, idle capture edge 5, valid one edge later
        check("b2b second time", 32'(t2), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
